// File: rtl/oisc_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch, data read and data write.
// Grant->MemReqValid 1 cycle, MemRspValid->RspValid 1 cycle; new requests see ReqReady low while Busy.
module oisc_mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IFReqValid,
  output logic          IFReqReady,
  input  logic [AW-1:0] IFAddr,
  output logic          IFRspValid,
  output logic [DW-1:0] IFRspData,
  input  logic          DRReqValid,
  output logic          DRReqReady,
  input  logic [AW-1:0] DRAddr,
  output logic          DRRspValid,
  output logic [DW-1:0] DRRspData,
  input  logic          DWReqValid,
  output logic          DWReqReady,
  input  logic [AW-1:0] DWAddr,
  input  logic [DW-1:0] DWData,
  output logic          MemReqValid,
  input  logic          MemReqReady,
  output logic          MemReqWrite,
  output logic [AW-1:0] MemReqAddr,
  output logic [DW-1:0] MemReqWData,
  input  logic          MemRspValid,
  input  logic [DW-1:0] MemRspData,
  output logic          Busy,
  output logic          ErrSpurious
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_DR, OWN_DW} owner_t;

  state_t state, stateNext;
  owner_t owner, lastGrant, grantSel;
  logic   anyReq, doGrant, rspFire, spurious;

  assign anyReq = IFReqValid | DRReqValid | DWReqValid;

  // Search begins just after the previous winner so no requester can starve
  always_comb begin
    grantSel = OWN_IF;
    case (lastGrant)
      OWN_IF:  grantSel = DRReqValid ? OWN_DR : (DWReqValid ? OWN_DW : OWN_IF);
      OWN_DR:  grantSel = DWReqValid ? OWN_DW : (IFReqValid ? OWN_IF : OWN_DR);
      default: grantSel = IFReqValid ? OWN_IF : (DRReqValid ? OWN_DR : OWN_DW);
    endcase
  end

  always_comb begin
    stateNext = state;
    doGrant   = 1'b0;
    rspFire   = 1'b0;
    spurious  = 1'b0;
    case (state)
      IDLE: begin
        spurious = MemRspValid;
        if (anyReq) begin
          doGrant   = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        spurious = MemRspValid;
        if (MemReqValid && MemReqReady) stateNext = MemReqWrite ? IDLE : WAIT;
      end
      WAIT: begin
        if (MemRspValid) begin
          rspFire   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lastGrant   <= OWN_DW;
      owner       <= OWN_IF;
      IFReqReady  <= 1'b0;
      DRReqReady  <= 1'b0;
      DWReqReady  <= 1'b0;
      IFRspValid  <= 1'b0;
      DRRspValid  <= 1'b0;
      IFRspData   <= '0;
      DRRspData   <= '0;
      MemReqValid <= 1'b0;
      MemReqWrite <= 1'b0;
      MemReqAddr  <= '0;
      MemReqWData <= '0;
      Busy        <= 1'b0;
      ErrSpurious <= 1'b0;
    end else begin
      IFReqReady  <= doGrant && (grantSel == OWN_IF);
      DRReqReady  <= doGrant && (grantSel == OWN_DR);
      DWReqReady  <= doGrant && (grantSel == OWN_DW);
      MemReqValid <= (stateNext == ISSUE);
      Busy        <= (stateNext != IDLE);
      ErrSpurious <= ErrSpurious | spurious;
      IFRspValid  <= rspFire && (owner == OWN_IF);
      DRRspValid  <= rspFire && (owner == OWN_DR);
      if (rspFire && (owner == OWN_IF)) IFRspData <= MemRspData;
      if (rspFire && (owner == OWN_DR)) DRRspData <= MemRspData;
      if (doGrant) begin
        owner       <= grantSel;
        lastGrant   <= grantSel;
        MemReqWrite <= (grantSel == OWN_DW);
        case (grantSel)
          OWN_IF:  MemReqAddr <= IFAddr;
          OWN_DR:  MemReqAddr <= DRAddr;
          default: begin
            MemReqAddr  <= DWAddr;
            MemReqWData <= DWData;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oisc_mem_arbiter.sv
// Bench for oisc_mem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios followed by a randomized traffic phase.
module tb_oisc_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IFReqValid, IFReqReady, IFRspValid;
  logic [AW-1:0] IFAddr;
  logic [DW-1:0] IFRspData;
  logic          DRReqValid, DRReqReady, DRRspValid;
  logic [AW-1:0] DRAddr;
  logic [DW-1:0] DRRspData;
  logic          DWReqValid, DWReqReady;
  logic [AW-1:0] DWAddr;
  logic [DW-1:0] DWData;
  logic          MemReqValid, MemReqReady, MemReqWrite;
  logic [AW-1:0] MemReqAddr;
  logic [DW-1:0] MemReqWData;
  logic          MemRspValid;
  logic [DW-1:0] MemRspData;
  logic          Busy, ErrSpurious;

  always #5 CLK = ~CLK;

  oisc_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .IFReqValid(IFReqValid), .IFReqReady(IFReqReady), .IFAddr(IFAddr),
    .IFRspValid(IFRspValid), .IFRspData(IFRspData),
    .DRReqValid(DRReqValid), .DRReqReady(DRReqReady), .DRAddr(DRAddr),
    .DRRspValid(DRRspValid), .DRRspData(DRRspData),
    .DWReqValid(DWReqValid), .DWReqReady(DWReqReady), .DWAddr(DWAddr), .DWData(DWData),
    .MemReqValid(MemReqValid), .MemReqReady(MemReqReady), .MemReqWrite(MemReqWrite),
    .MemReqAddr(MemReqAddr), .MemReqWData(MemReqWData),
    .MemRspValid(MemRspValid), .MemRspData(MemRspData),
    .Busy(Busy), .ErrSpurious(ErrSpurious)
  );

  int vecCnt = 0;
  int errCnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Requesters: a pending request is held on its port until the model says it was granted
  bit            pend[3];
  logic [AW-1:0] pAddr[3];
  logic [DW-1:0] pData;
  int newReqPct = 0, dropPct = 0;

  // Memory side
  int readyMode = 1;            // 0 random, 1 always ready, 2 never ready
  int fixedDelay = -1;          // -1 random response delay
  int rspWait = -1;
  bit useForce = 0;
  logic [DW-1:0] forceData;

  // Reference model: at most one transaction in flight, round-robin over IF, DR, DW
  bit            mActive, mIssued, mWrite, mErr;
  int            mOwner, mLast;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWData;
  logic [DW-1:0] mRsp[3];
  logic [2:0]    expReady, expRspV;

  int grantLog[$];
  int memVldCnt, dwRdyCnt, ifRspCnt, drRspCnt;

  task automatic modelEdge();
    logic [2:0] v;
    int g;
    bit found;
    v = {DWReqValid, DRReqValid, IFReqValid};
    expReady = '0;
    expRspV  = '0;
    if (RST) begin
      mActive = 0; mIssued = 0; mWrite = 0; mErr = 0; mLast = 2; mOwner = 0;
      mAddr = '0; mWData = '0;
      for (int i = 0; i < 3; i++) mRsp[i] = '0;
      return;
    end
    if (!mActive) begin
      if (MemRspValid) mErr = 1;
      found = 0;
      g = 0;
      for (int k = 1; k <= 3; k++) begin
        if (!found && v[(mLast + k) % 3]) begin
          found = 1;
          g = (mLast + k) % 3;
        end
      end
      if (found) begin
        expReady[g] = 1'b1;
        mActive = 1; mIssued = 0; mOwner = g; mLast = g; mWrite = (g == 2);
        mAddr = (g == 0) ? IFAddr : (g == 1) ? DRAddr : DWAddr;
        if (g == 2) mWData = DWData;
        pend[g] = 0;
      end
    end else if (!mIssued) begin
      if (MemRspValid) mErr = 1;
      if (MemReqReady) begin
        if (mWrite) mActive = 0;
        else        mIssued = 1;
      end
    end else if (MemRspValid) begin
      mRsp[mOwner] = MemRspData;
      expRspV[mOwner] = 1'b1;
      mActive = 0;
      mIssued = 0;
    end
  endtask

  task automatic checkOut();
    chk("reqReady", {DWReqReady, DRReqReady, IFReqReady}, expReady);
    chk("rspValid", {DRRspValid, IFRspValid}, expRspV[1:0]);
    chk("memReqValid", MemReqValid, mActive && !mIssued);
    chk("busy", Busy, mActive);
    chk("errSpurious", ErrSpurious, mErr);
    chk("ifRspData", IFRspData, mRsp[0]);
    chk("drRspData", DRRspData, mRsp[1]);
    if (mActive && !mIssued) begin
      chk("memWrite", MemReqWrite, mWrite);
      chk("memAddr", MemReqAddr, mAddr);
      if (mWrite) chk("memWData", MemReqWData, mWData);
    end
    if (IFReqReady) grantLog.push_back(0);
    if (DRReqReady) grantLog.push_back(1);
    if (DWReqReady) grantLog.push_back(2);
    if (MemReqValid) memVldCnt++;
    if (DWReqReady)  dwRdyCnt++;
    if (IFRspValid)  ifRspCnt++;
    if (DRRspValid)  drRspCnt++;
  endtask

  task automatic applyReqs();
    IFReqValid = pend[0]; IFAddr = pAddr[0];
    DRReqValid = pend[1]; DRAddr = pAddr[1];
    DWReqValid = pend[2]; DWAddr = pAddr[2]; DWData = pData;
  endtask

  task automatic idleReqs();
    for (int i = 0; i < 3; i++) pend[i] = 0;
    applyReqs();
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (pend[i] && $urandom_range(99) < dropPct) pend[i] = 0;
      else if (!pend[i] && $urandom_range(99) < newReqPct) begin
        pend[i]  = 1;
        pAddr[i] = AW'($urandom);
        if (i == 2) pData = $urandom;
      end
    end
    applyReqs();
    case (readyMode)
      0:       MemReqReady = 1'($urandom_range(1));
      1:       MemReqReady = 1'b1;
      default: MemReqReady = 1'b0;
    endcase
    MemRspValid = 1'b0;
    MemRspData  = $urandom;
    if (mActive && mIssued) begin
      if (rspWait < 0) rspWait = (fixedDelay >= 0) ? fixedDelay : $urandom_range(2);
      if (rspWait == 0) begin
        MemRspValid = 1'b1;
        if (useForce) MemRspData = forceData;
        rspWait = -1;
      end else rspWait--;
    end else rspWait = -1;
  endtask

  task automatic tick();
    @(posedge CLK);
    modelEdge();
    @(negedge CLK);
    checkOut();
    drive();
  endtask

  task automatic drain();
    newReqPct = 0; dropPct = 0; readyMode = 1; fixedDelay = -1; useForce = 0;
    idleReqs();
    for (int c = 0; c < 40 && mActive; c++) tick();
    tick();
  endtask

  int rrExp[4] = '{0, 1, 2, 0};

  initial begin
    for (int i = 0; i < 3; i++) begin pend[i] = 0; pAddr[i] = '0; end
    pData = '0;
    applyReqs();
    MemReqReady = 1'b0; MemRspValid = 1'b0; MemRspData = '0;
    RST = 1'b1;
    tick();
    tick();
    chk("rstMemAddr", MemReqAddr, '0);
    chk("rstMemWData", MemReqWData, '0);
    chk("rstMemWrite", MemReqWrite, 1'b0);
    RST = 1'b0;

    // All three requesters valid continuously: order IF, DR, DW, IF
    newReqPct = 100; readyMode = 1; fixedDelay = 1;
    for (int i = 0; i < 3; i++) begin pend[i] = 1; pAddr[i] = AW'($urandom); end
    pData = $urandom;
    applyReqs();
    MemReqReady = 1'b1;
    grantLog.delete();
    for (int c = 0; c < 60 && grantLog.size() < 4; c++) tick();
    chk("rrGrantCount", grantLog.size(), 4);
    for (int k = 0; k < 4; k++)
      if (grantLog.size() > k) chk("rrOrder", grantLog[k], rrExp[k]);
    drain();

    // Stalled write: MemReqReady low for three cycles
    pend[2] = 1; pAddr[2] = 16'h0010; pData = 32'hDEADBEEF;
    applyReqs();
    MemReqReady = 1'b0;
    memVldCnt = 0; dwRdyCnt = 0;
    for (int c = 0; c < 8; c++) begin
      readyMode = (c >= 3) ? 1 : 2;
      tick();
    end
    chk("wrVldCycles", memVldCnt, 4);
    chk("wrReadyPulses", dwRdyCnt, 1);
    drain();

    // Data read with a known response value
    pend[1] = 1; pAddr[1] = 16'h00FF;
    applyReqs();
    useForce = 1; forceData = 32'h12345678;
    ifRspCnt = 0; drRspCnt = 0;
    for (int c = 0; c < 10; c++) tick();
    chk("drRspPulses", drRspCnt, 1);
    chk("ifRspPulses", ifRspCnt, 0);
    chk("drRspValue", DRRspData, 32'h12345678);
    drain();

    // Spurious response while idle is sticky and routes nowhere
    ifRspCnt = 0; drRspCnt = 0;
    MemRspValid = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("spurSticky", ErrSpurious, 1'b1);
    chk("spurNoRsp", ifRspCnt + drRspCnt, 0);

    // Reset mid-read, then a late response
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("errCleared", ErrSpurious, 1'b0);
    fixedDelay = 5;
    pend[1] = 1; pAddr[1] = AW'($urandom);
    applyReqs();
    for (int c = 0; c < 20 && !(mActive && mIssued); c++) tick();
    chk("reachedWait", Busy && !MemReqValid, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abortBusy", Busy, 1'b0);
    ifRspCnt = 0; drRspCnt = 0;
    MemRspValid = 1'b1;
    tick();
    tick();
    chk("abortSpur", ErrSpurious, 1'b1);
    chk("abortNoRsp", ifRspCnt + drRspCnt, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;

    // Randomized traffic with stalls, drops and variable response delay
    readyMode = 0; newReqPct = 30; dropPct = 5; fixedDelay = -1;
    for (int c = 0; c < 3000; c++) tick();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
